booth_multiplier_seq: RTL and testbench

Sequential radix-2 Booth multiplier that consumes the signed 8-bit operands A and B produced by the keypad operand-entry path and returns a signed 16-bit product. It sits between operand storage and the binary-to-BCD/7-segment display path. It accepts a one-cycle start request, iterates one Booth step per clock, and reports completion with a one-cycle done pulse plus a held product register.

---
 rtl/booth_multiplier_seq.sv | 140 ++++++++++++++
 tb/tb_booth_multiplier_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth 8x8 signed multiplier: start -> done in 9 cycles, start ignored while busy (no queueing).
// Optional BOOTH_ABS_OUT_EN adds registered product_mag/product_neg for the unsigned BCD display path.
module booth_multiplier_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
`ifdef BOOTH_ABS_OUT_EN
  ,
  output logic [15:0] product_mag,
  output logic        product_neg
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  m_q, m_d;
  logic [7:0]  q_q, q_d;
  logic [8:0]  acc_q, acc_d;
  logic        qm1_q, qm1_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;

  logic        accept;
  logic        last_iter;
  logic [8:0]  m_sext;
  logic [8:0]  acc_sum;

  assign accept    = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign last_iter = (cnt_q == 4'd8);
  assign m_sext    = {m_q[7], m_q};

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= 8'h00;
      q_q       <= 8'h00;
      acc_q     <= 9'h000;
      qm1_q     <= 1'b0;
      cnt_q     <= 4'd0;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + m_sext;
      2'b10:   acc_sum = acc_q - m_sext;
      default: acc_sum = acc_q;
    endcase
  end

  // Datapath: capture on accept, one Booth step per RUN cycle, final cycle publishes the product
  always_comb begin
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (accept) begin
      m_d   = a_in;
      q_d   = b_in;
      acc_d = 9'h000;
      qm1_d = 1'b0;
      cnt_d = 4'd0;
    end else if (state_q == RUN) begin
      if (last_iter) begin
        product_d = {acc_q[7:0], q_q};
      end else begin
        acc_d = {acc_sum[8], acc_sum[8:1]};
        q_d   = {acc_sum[0], q_q[7:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Output logic
  always_comb begin
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    product = product_q;
  end

`ifdef BOOTH_ABS_OUT_EN
  logic [15:0] product_mag_q, product_mag_d;
  logic        product_neg_q, product_neg_d;

  // Derived from product_d so both track product on exactly the same edge
  always_comb begin
    product_neg_d = product_d[15];
    product_mag_d = product_d[15] ? (16'h0000 - product_d) : product_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      product_mag_q <= 16'h0000;
      product_neg_q <= 1'b0;
    end else begin
      product_mag_q <= product_mag_d;
      product_neg_q <= product_neg_d;
    end
  end

  assign product_mag = product_mag_q;
  assign product_neg = product_neg_q;
`endif

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Bench for booth_multiplier_seq: directed spec vectors plus randomized operands against an arithmetic reference.
module tb_booth_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy;
  logic        done;
  logic [15:0] product;
`ifdef BOOTH_ABS_OUT_EN
  logic [15:0] product_mag;
  logic        product_neg;
`endif

  booth_multiplier_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .product     (product)
`ifdef BOOTH_ABS_OUT_EN
    ,
    .product_mag (product_mag),
    .product_neg (product_neg)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] last_prod;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input logic [15:0] exp);
    check("done_pulse", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("product", product, exp);
`ifdef BOOTH_ABS_OUT_EN
    check("product_neg", product_neg, exp[15]);
    check("product_mag", product_mag, exp[15] ? 16'(-int'($signed(exp))) : exp);
`endif
    last_prod = exp;
  endtask

  // Caller is #1 after an edge; one start pulse, 9 busy cycles, done, then back to idle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit scramble);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check("busy_run", busy, 1'b1);
      check("done_run", done, 1'b0);
      check("prod_hold", product, last_prod);
      if (scramble) begin
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      tick();
    end
    start = 1'b0;
    check_result(exp);
    tick();
    check("done_one_cycle", done, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = 8'h00;
    b_in  = 8'h00;
    last_prod = 16'h0000;
    tick();
    start = 1'b1;
    a_in  = 8'd3;
    b_in  = 8'd3;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_product", product, 16'h0000);
`ifdef BOOTH_ABS_OUT_EN
    check("rst_mag", product_mag, 16'h0000);
    check("rst_neg", product_neg, 1'b0);
`endif
    start = 1'b0;
    rst   = 1'b0;
    tick();

    run_op(8'd7,   8'd3,   16'h0015, 1'b0);
    run_op(8'hFB,  8'd6,   16'hFFE2, 1'b0);
    run_op(8'h80,  8'h80,  16'h4000, 1'b0);
    run_op(8'h80,  8'h7F,  16'hC080, 1'b0);
    run_op(8'h00,  8'hFF,  16'h0000, 1'b0);
    run_op(8'h7F,  8'h7F,  16'h3F01, 1'b0);

    // start held high: second run launches straight from DONE
    a_in  = 8'd2;
    b_in  = 8'd3;
    start = 1'b1;
    tick();
    a_in  = 8'd4;
    b_in  = 8'd5;
    for (int k = 0; k < 9; k++) begin
      check("b2b_busy1", busy, 1'b1);
      tick();
    end
    check_result(16'h0006);
    tick();
    for (int k = 0; k < 9; k++) begin
      check("b2b_busy2", busy, 1'b1);
      check("b2b_done2", done, 1'b0);
      tick();
    end
    start = 1'b0;
    check_result(16'h0014);
    tick();
    check("b2b_idle", busy, 1'b0);

    // Reset during iteration 4 aborts the operation
    a_in  = 8'd9;
    b_in  = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_product", product, 16'h0000);
    last_prod = 16'h0000;
    for (int k = 0; k < 12; k++) begin
      check("abort_no_done", done, 1'b0);
      tick();
    end
    run_op(8'd9, 8'd9, 16'h0051, 1'b0);

    // Randomized operands, scrambled inputs and stray start pulses during RUN
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, ref_mul(ra, rb), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
